// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// Cycle-stealing arbiter for the shared 64 KiB synchronous memory port.
// Stalls the CPU during bounded DMA bursts and replays the interrupted CPU read.
module mem_bus_arbiter #(
    parameter int DMA_MAX_BURST = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] cpu_address_in,
    input  logic        cpu_read_write_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic        dma_write,
    input  logic [7:0]  dma_wdata,
    output logic        dma_grant,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_address,
    output logic        mem_write,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [1:0] {CPU_OWN, DMA_OWN, RETURN} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } mem_req_t;

    localparam logic [7:0] BURST_MAX = 8'(DMA_MAX_BURST);

    state_t      state, state_nxt;
    logic [7:0]  burst_cnt, burst_cnt_nxt, burst_inc;
    logic [15:0] held_addr, held_addr_nxt;
    logic        cooldown, cooldown_nxt;
    logic        rd_pend, rd_pend_nxt;
    mem_req_t    mem_req;

    assign burst_inc = burst_cnt + 8'd1;

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        held_addr_nxt = held_addr;
        cooldown_nxt  = cooldown;
        rd_pend_nxt   = 1'b0;
        cpu_ready     = 1'b1;
        dma_grant     = 1'b0;
        mem_req.addr  = cpu_address_in;
        mem_req.we    = cpu_read_write_in;
        mem_req.wdata = cpu_wdata_in;
        case (state)
            CPU_OWN: begin
                cooldown_nxt = 1'b0;
                // Only steal a read cycle; that read is reissued from held_addr later.
                if (dma_req && !cpu_read_write_in && !cooldown) begin
                    held_addr_nxt = cpu_address_in;
                    state_nxt     = DMA_OWN;
                end
            end
            DMA_OWN: begin
                cpu_ready     = 1'b0;
                dma_grant     = 1'b1;
                mem_req.addr  = dma_address;
                mem_req.we    = 1'b0;
                mem_req.wdata = dma_wdata;
                if (dma_req) begin
                    mem_req.we    = dma_write;
                    burst_cnt_nxt = burst_inc;
                    rd_pend_nxt   = !dma_write;
                    if (burst_inc == BURST_MAX)
                        state_nxt = RETURN;
                end else begin
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                cpu_ready     = 1'b0;
                mem_req.addr  = held_addr;
                mem_req.we    = 1'b0;
                burst_cnt_nxt = 8'd0;
                cooldown_nxt  = 1'b1;
                state_nxt     = CPU_OWN;
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= CPU_OWN;
            burst_cnt <= 8'd0;
            held_addr <= 16'h0000;
            cooldown  <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            held_addr <= held_addr_nxt;
            cooldown  <= cooldown_nxt;
            rd_pend   <= rd_pend_nxt;
        end
    end

    assign mem_address   = mem_req.addr;
    assign mem_write     = mem_req.we;
    assign mem_wdata     = mem_req.wdata;
    assign cpu_rdata_out = mem_rdata;
    assign dma_rdata     = mem_rdata;
    assign dma_rvalid    = rd_pend;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_bus_arbiter with a synchronous memory model and
// a read-data scoreboard for DMA reads and CPU replays.
module tb_mem_bus_arbiter;
    logic        clk_in = 1'b0;
    logic        reset;
    logic [15:0] cpu_address_in;
    logic        cpu_read_write_in;
    logic [7:0]  cpu_wdata_in;
    logic [7:0]  cpu_rdata_out;
    logic        cpu_ready;
    logic        dma_req;
    logic [15:0] dma_address;
    logic        dma_write;
    logic [7:0]  dma_wdata;
    logic        dma_grant;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [15:0] mem_address;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_mem [int];
    logic [7:0]  q [$];
    logic        rv_pend = 1'b0;
    logic        prev_cpu_rd = 1'b0;
    int          prev_addr = 0;
    logic        rs_req = 1'b0;

    mem_bus_arbiter #(.DMA_MAX_BURST(4)) dut (
        .clk_in(clk_in), .reset(reset),
        .cpu_address_in(cpu_address_in), .cpu_read_write_in(cpu_read_write_in),
        .cpu_wdata_in(cpu_wdata_in), .cpu_rdata_out(cpu_rdata_out), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_address(dma_address), .dma_write(dma_write),
        .dma_wdata(dma_wdata), .dma_grant(dma_grant), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .mem_address(mem_address), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
        mem_rdata <= mem[mem_address];
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        logic [15:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rd_exp(input int a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return pat(16'(a));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational/registered outputs 1ns later.
    task automatic cyc(input logic [15:0] ca, input logic crw, input logic [7:0] cwd,
                       input logic dr, input logic [15:0] da, input logic dw, input logic [7:0] dwd,
                       input logic e_rdy, input logic e_gnt, input int e_addr, input logic e_we);
        logic rd_now;
        @(negedge clk_in);
        reset = rs_req;
        rs_req = 1'b0;
        cpu_address_in = ca; cpu_read_write_in = crw; cpu_wdata_in = cwd;
        dma_req = dr; dma_address = da; dma_write = dw; dma_wdata = dwd;
        #1;
        chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, e_rdy});
        chk("dma_grant", {31'd0, dma_grant}, {31'd0, e_gnt});
        chk("mem_write", {31'd0, mem_write}, {31'd0, e_we});
        if (e_addr >= 0) chk("mem_address", {16'd0, mem_address}, 32'(e_addr));
        if (e_we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e_gnt ? dwd : cwd});
        chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, rv_pend});
        if (rv_pend) begin
            if (q.size() == 0) chk("dma_scoreboard_empty", 32'd0, 32'd1);
            else chk("dma_rdata", {24'd0, dma_rdata}, {24'd0, q.pop_front()});
        end
        if (e_rdy && prev_cpu_rd)
            chk("cpu_rdata", {24'd0, cpu_rdata_out}, {24'd0, rd_exp(prev_addr)});
        if (e_we && e_addr >= 0) exp_mem[e_addr] = e_gnt ? dwd : cwd;
        rd_now = e_gnt && dr && !dw && !reset;
        if (rd_now) q.push_back(rd_exp(int'(da)));
        rv_pend = rd_now;
        prev_cpu_rd = !e_gnt && !e_we && e_addr >= 0;
        prev_addr = e_addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        reset = 1'b1;
        cpu_address_in = 16'h1234; cpu_read_write_in = 1'b0; cpu_wdata_in = 8'h00;
        dma_req = 1'b0; dma_address = 16'h0000; dma_write = 1'b0; dma_wdata = 8'h00;
        repeat (3) @(negedge clk_in);

        // Idle after reset: CPU owns the bus.
        repeat (3) cyc(16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h1234, 0);

        // Full 4-access read burst stolen from a CPU read of 0x0200.
        cyc(16'h0200, 0, 8'h00, 1, 16'h8000, 0, 8'h00, 1, 0, 'h0200, 0);
        for (int i = 0; i < 4; i++)
            cyc(16'h0200, 0, 8'h00, 1, 16'(16'h8000 + i), 0, 8'h00, 0, 1, 'h8000 + i, 0);
        cyc(16'h0200, 0, 8'h00, 1, 16'h8004, 0, 8'h00, 0, 0, 'h0200, 0);
        cyc(16'h0200, 0, 8'h00, 1, 16'h8004, 0, 8'h00, 1, 0, 'h0200, 0);
        cyc(16'h0201, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h0201, 0);

        // Request during a CPU write waits for the following read; DMA writes then drops.
        cyc(16'h0300, 1, 8'h3C, 1, 16'h4000, 1, 8'hA5, 1, 0, 'h0300, 1);
        cyc(16'h0300, 0, 8'h00, 1, 16'h4000, 1, 8'hA5, 1, 0, 'h0300, 0);
        cyc(16'h0300, 0, 8'h00, 1, 16'h4000, 1, 8'hA5, 0, 1, 'h4000, 1);
        cyc(16'h0300, 0, 8'h00, 1, 16'h4001, 1, 8'h5A, 0, 1, 'h4001, 1);
        cyc(16'h0300, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, -1, 0);
        cyc(16'h0300, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 'h0300, 0);
        cyc(16'h0300, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h0300, 0);
        cyc(16'h4000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h4000, 0);
        cyc(16'h4001, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h4001, 0);
        cyc(16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h1234, 0);

        // Reset in the second grant cycle of a read burst.
        cyc(16'h0500, 0, 8'h00, 1, 16'h9000, 0, 8'h00, 1, 0, 'h0500, 0);
        cyc(16'h0500, 0, 8'h00, 1, 16'h9000, 0, 8'h00, 0, 1, 'h9000, 0);
        rs_req = 1'b1;
        cyc(16'h0500, 0, 8'h00, 1, 16'h9001, 0, 8'h00, 0, 1, 'h9001, 0);
        cyc(16'h0500, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h0500, 0);
        // A fresh burst must run the full limit, showing the counter restarted.
        cyc(16'h0501, 0, 8'h00, 1, 16'hA000, 0, 8'h00, 1, 0, 'h0501, 0);
        for (int i = 0; i < 4; i++)
            cyc(16'h0501, 0, 8'h00, 1, 16'(16'hA000 + i), 0, 8'h00, 0, 1, 'hA000 + i, 0);
        cyc(16'h0501, 0, 8'h00, 1, 16'hA004, 0, 8'h00, 0, 0, 'h0501, 0);
        cyc(16'h0501, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h0501, 0);
        cyc(16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 'h1234, 0);

        chk("mem_4000", {24'd0, mem[16'h4000]}, 32'h0000_00A5);
        chk("mem_0300", {24'd0, mem[16'h0300]}, 32'h0000_003C);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Cycle-stealing arbiter sharing the single 64 KiB synchronous memory port between `cpu6502` and one DMA requester (loader/video fetch). It sits between the CPU's `address_out`/`data_out`/`READ_write` and the memory. It stalls the CPU through a ready line, grants bounded DMA bursts, and replays the interrupted CPU read so the CPU resumes with valid data.

## Interface
- `DMA_MAX_BURST`, default 4, maximum DMA accesses per grant (legal range 1..255).
- `clk_in`  input  1  single system clock, all state on rising edge.
- `reset`  input  1  synchronous, active-high.
- `cpu_address_in`  input  16  CPU address (`address_out`).
- `cpu_read_write_in`  input  1  CPU direction, 0 read, 1 write (`READ_write`).
- `cpu_wdata_in`  input  8  CPU write data (`data_out`).
- `cpu_rdata_out`  output  8  read data to CPU `data_in`.
- `cpu_ready`  output  1  1 = CPU may advance; 0 = CPU must hold its bus and state.
- `dma_req`  input  1  DMA access request, qualified each cycle.
- `dma_address`  input  16  DMA address.
- `dma_write`  input  1  0 read, 1 write.
- `dma_wdata`  input  8  DMA write data.
- `dma_grant`  output  1  DMA owns memory this cycle; access performed iff `dma_req`=1.
- `dma_rdata`  output  8  DMA read data.
- `dma_rvalid`  output  1  `dma_rdata` valid (one cycle after a granted DMA read).
- `mem_address`  output  16  memory address.
- `mem_write`  output  1  memory write enable; write commits at this edge.
- `mem_wdata`  output  8  memory write data.
- `mem_rdata`  input  8  memory read data, one-cycle latency.

## Operation
- States: `CPU_OWN`, `DMA_OWN`, `RETURN`. Registers: state, burst counter (8 bit), held CPU address (16 bit), cooldown flag, DMA-read-pending flag.
- Reset values: state `CPU_OWN`, `cpu_ready`=1, `dma_grant`=0, `dma_rvalid`=0, counter 0, cooldown 0, held address 0x0000.
- `CPU_OWN`: `mem_address`=`cpu_address_in`, `mem_write`=`cpu_read_write_in`, `mem_wdata`=`cpu_wdata_in`. If `dma_req`=1, `cpu_read_write_in`=0 and cooldown=0: latch `cpu_address_in` into held address, go `DMA_OWN`. The current CPU read is issued but discarded. CPU writes are never interrupted; grant waits for a CPU read cycle. Cooldown is cleared after every `CPU_OWN` cycle.
- `DMA_OWN`: `cpu_ready`=0, `dma_grant`=1.
  - `dma_req`=1: drive `mem_*` from DMA and increment the counter. A read sets DMA-read-pending.
  - `dma_req`=0: `mem_write`=0 and no access is counted.
  - Go `RETURN` when `dma_req`=0, or when the counter reaches `DMA_MAX_BURST` after this access.
- `RETURN`: `cpu_ready`=0, `dma_grant`=0, `mem_address`=held address, `mem_write`=0. Clear the counter, set cooldown=1, then go `CPU_OWN`.
- `cpu_rdata_out` = `mem_rdata` combinationally. It is valid in the cycle after a CPU read address was presented, including the first `CPU_OWN` cycle after `RETURN`.
- `dma_rdata` = `mem_rdata`. `dma_rvalid` = registered DMA-read-pending, which may assert during `RETURN`.
- Addresses pass through unmodified; no wrap or translation.

## Timing
- Grant latency: with `dma_req` high in a `CPU_OWN` read cycle N, `dma_grant`=1 and `cpu_ready`=0 in cycle N+1.
- Burst of k accesses (k ≤ `DMA_MAX_BURST`) occupies k grant cycles. Ending on the burst limit: `RETURN` follows the last access. Ending on a request drop: one extra grant cycle with no access (the cycle `dma_req` is seen low), then `RETURN`.
- CPU is stalled for (grant cycles + 1) cycles. `cpu_ready` returns to 1 in the cycle after `RETURN`, with the replayed read data on `cpu_rdata_out`.
- Fairness: after any burst, the CPU gets at least one `CPU_OWN` cycle before the next grant, even if `dma_req` is still held.
- `dma_req` is sampled in the same cycle; there is no request latching. The requester holds it until it has seen `dma_grant`.
- Reset mid-burst: next cycle is `CPU_OWN` with `cpu_ready`=1. `dma_rvalid` is forced to 0 and the pending DMA read data is dropped. Any write presented in the reset cycle still commits.
- `DMA_MAX_BURST`=1: every grant is exactly 1 access + `RETURN`.

## Test plan
- After reset with `dma_req`=0 and the CPU reading 0x1234: `cpu_ready`=1 throughout, `mem_address`=0x1234, `dma_grant`=0, `dma_rvalid`=0.
- `dma_req` held during a CPU read of 0x0200, `DMA_MAX_BURST`=4, DMA reads 0x8000..0x8003: 4 grant cycles with `dma_rvalid` and data following each read by one cycle, then `RETURN` drives 0x0200. `cpu_ready`=1 after 5 stall cycles with memory[0x0200] on `cpu_rdata_out`, and at least 1 CPU cycle before the next grant.
- `dma_req` raised during a CPU write to 0x0300 followed by a CPU read: the write commits, and the grant starts only after the read cycle.
- DMA writes 0xA5 to 0x4000, then drops `dma_req` after 2 accesses (limit 4): memory[0x4000]=0xA5, one empty grant cycle, `RETURN`, then the CPU resumes.
- `reset` asserted in the 2nd grant cycle of a DMA read burst: the next cycle shows `cpu_ready`=1, `dma_grant`=0, `dma_rvalid`=0 and the counter at 0.
